// File: rtl/game_sequencer_pkg.sv
// FlappyBruin game-flow state codes and widths shared with render/score_board.
// GAME_SEQ_PAUSE_EN adds the PAUSE state code (5); otherwise codes 5-7 are unused.
package flappy_pkg;

  localparam int SCORE_W = 10;
  localparam int FCNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    CRASH = 3'd3,
    OVER  = 3'd4
`ifdef GAME_SEQ_PAUSE_EN
    ,
    PAUSE = 3'd5
`endif
  } game_state_t;

endpackage

// File: rtl/game_sequencer_button_conditioner.sv
// Raw push-button conditioner: 2-FF synchronizer, counter debounce and a
// registered one-cycle rise pulse that follows the debounced level by one cycle.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_25MHz,
  input  logic reset_n,
  input  logic in_raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          level_d;

  // Any sample that agrees with the current level restarts the count, so bounces never leak through.
  always_ff @(posedge clk_25MHz) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], in_raw};
      level_d <= level;
      rise    <= level & ~level_d;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// FlappyBruin game-flow controller: IDLE -> READY -> PLAY -> CRASH -> OVER, timed in VGA frames.
// Define GAME_SEQ_PAUSE_EN to add the btn_pause input and the PAUSE state.
module game_sequencer
  import flappy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int READY_FRAMES     = 120,
  parameter int CRASH_FRAMES     = 90,
  parameter int FLASH_FRAMES     = 8,
  parameter int OVER_LOCK_FRAMES = 30
) (
  input  logic               clk_25MHz,
  input  logic               reset_n,
  input  logic               btn_start,
  input  logic               btn_flap,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic               btn_pause,
`endif
  input  logic               vsync,
  input  logic               lose,
  input  logic [SCORE_W-1:0] score,
  output logic               run,
  output logic               clear,
  output logic               flap_pulse,
  output logic               flash,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] best_score
);

  localparam logic [FCNT_W-1:0] READY_LAST = FCNT_W'(READY_FRAMES - 1);
  localparam logic [FCNT_W-1:0] CRASH_LAST = FCNT_W'(CRASH_FRAMES - 1);
  localparam logic [FCNT_W-1:0] FLASH_LAST = FCNT_W'(FLASH_FRAMES - 1);
  localparam logic [FCNT_W-1:0] OVER_LOCK  = FCNT_W'(OVER_LOCK_FRAMES);
  localparam logic [FCNT_W-1:0] FCNT_MAX   = '1;

  game_state_t       cur_state, next_state;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] flash_cnt;
  logic              vsync_q, frame_tick;
  logic              start_level, start_rise;
  logic              flap_level, flap_rise;
  logic              state_changed, flap_take, fcnt_freeze;
  logic              unused_levels;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_cond (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n), .in_raw(btn_start),
    .level(start_level), .rise(start_rise)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_flap_cond (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n), .in_raw(btn_flap),
    .level(flap_level), .rise(flap_rise)
  );

`ifdef GAME_SEQ_PAUSE_EN
  logic pause_level, pause_rise;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_cond (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n), .in_raw(btn_pause),
    .level(pause_level), .rise(pause_rise)
  );

  assign unused_levels = start_level ^ flap_level ^ pause_level;
  assign fcnt_freeze   = (cur_state == PAUSE);
`else
  assign unused_levels = start_level ^ flap_level;
  assign fcnt_freeze   = 1'b0;
`endif

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:  if (start_rise) next_state = READY;
      READY: if (flap_rise || (frame_tick && fcnt == READY_LAST)) next_state = PLAY;
      PLAY: begin
        if (lose) next_state = CRASH;
`ifdef GAME_SEQ_PAUSE_EN
        else if (pause_rise) next_state = PAUSE;
`endif
      end
      CRASH: if (frame_tick && fcnt == CRASH_LAST) next_state = OVER;
      OVER:  if (start_rise && fcnt >= OVER_LOCK) next_state = READY;
`ifdef GAME_SEQ_PAUSE_EN
      PAUSE: if (pause_rise || start_rise) next_state = PLAY;
`endif
      default: next_state = IDLE;
    endcase
  end

  assign state_changed = (next_state != cur_state);
  // A flap counts only when it keeps or brings us into PLAY; a simultaneous crash swallows it.
  assign flap_take     = flap_rise && (next_state == PLAY) &&
                         ((cur_state == PLAY) || (cur_state == READY));
  assign state         = cur_state;

  always_ff @(posedge clk_25MHz) begin
    if (!reset_n) begin
      cur_state  <= IDLE;
      fcnt       <= '0;
      flash_cnt  <= '0;
      flash      <= 1'b0;
      run        <= 1'b0;
      clear      <= 1'b0;
      flap_pulse <= 1'b0;
      best_score <= '0;
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vsync_q & ~vsync;
      cur_state  <= next_state;
      run        <= (next_state == PLAY);
      clear      <= state_changed && (next_state == READY);
      flap_pulse <= flap_take;

      if (state_changed) begin
        fcnt <= '0;
      end else if (frame_tick && !fcnt_freeze && fcnt != FCNT_MAX) begin
        fcnt <= fcnt + 1'b1;
      end

      // Flash starts lit on CRASH entry and is forced dark everywhere else.
      if (next_state != CRASH) begin
        flash     <= 1'b0;
        flash_cnt <= '0;
      end else if (cur_state != CRASH) begin
        flash     <= 1'b1;
        flash_cnt <= '0;
      end else if (frame_tick) begin
        if (flash_cnt == FLASH_LAST) begin
          flash     <= ~flash;
          flash_cnt <= '0;
        end else begin
          flash_cnt <= flash_cnt + 1'b1;
        end
      end

      if (cur_state == PLAY && next_state == CRASH && score > best_score) begin
        best_score <= score;
      end
    end
  end

endmodule
